// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator controller.
// Build option: CALC_CHAIN_EN enables chaining a result into the next operation.
package calc_pkg;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_RES = 3'd3,
        S_ERR = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;

    // Largest magnitude representable with ndig decimal digits.
    function automatic int calc_max(input int ndig);
        int m;
        m = 1;
        for (int i = 0; i < ndig; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/calc_if.sv
// Key-event bundle from the keypad decoder and the display-side results.
// master drives keys and observes the display; slave is the controller.
interface calc_if #(
    parameter int W = 14
) ();
    logic         key_valid;
    logic         key_is_num;
    logic         key_is_op;
    logic         key_is_eq;
    logic [3:0]   key_num;
    logic [1:0]   key_op;
    logic [W-1:0] disp_val;
    logic         disp_neg;
    logic         err;
    logic         result_valid;
    logic [2:0]   state_o;

    modport master (
        output key_valid, key_is_num, key_is_op, key_is_eq, key_num, key_op,
        input  disp_val, disp_neg, err, result_valid, state_o
    );

    modport slave (
        input  key_valid, key_is_num, key_is_op, key_is_eq, key_num, key_op,
        output disp_val, disp_neg, err, result_valid, state_o
    );
endinterface

// File: rtl/calc_alu.sv
// Combinational signed add/subtract of operand A and magnitude B,
// flagging results whose magnitude exceeds the display range.
module calc_alu
    import calc_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int W    = 14
) (
    input  logic signed [W+1:0] a,
    input  logic        [W-1:0] b,
    input  logic        [1:0]   op,
    output logic signed [W+1:0] r,
    output logic                ovf
);
    localparam int MAXI = calc_max(NDIG);
    localparam logic signed [W+1:0] MAX = MAXI[W+1:0];

    logic signed [W+1:0] b_s;
    logic signed [W+1:0] mag;

    // Sum or difference, then magnitude range check.
    always_comb begin
        b_s = $signed({2'b00, b});
        r   = (op == OP_SUB) ? (a - b_s) : (a + b_s);
        mag = r[W+1] ? -r : r;
        ovf = (mag > MAX);
    end
endmodule

// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: operand entry FSM, ALU hookup, display regs.
// Build option: CALC_CHAIN_EN lets an operator key in S_RES reuse the result.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int W    = 14
) (
    input  logic  clk,
    input  logic  reset,
    calc_if.slave bus
);
    localparam int MAXI = calc_max(NDIG);
    localparam int LIMI = (MAXI + 1) / 10;
    localparam logic signed [W+1:0] LIM_A = LIMI[W+1:0];
    localparam logic        [W-1:0] LIM_B = LIMI[W-1:0];

    state_t              state, nxt;
    logic signed [W+1:0] a, a_n;
    logic        [W-1:0] b, b_n;
    logic signed [W+1:0] r, r_n;
    logic        [1:0]   op, op_n;
    logic                rv_n;

    logic signed [W+1:0] alu_r;
    logic                alu_ovf;

    logic                is_num, is_op, is_eq;
    logic signed [W+1:0] d_a, a_x10;
    logic        [W-1:0] d_b, b_x10;

    logic        [W-1:0] val_n;
    logic                neg_n, err_n;

    logic        [W-1:0] disp_val_q;
    logic                disp_neg_q, err_q, rv_q;

    calc_alu #(.NDIG(NDIG), .W(W)) u_alu (
        .a   (a),
        .b   (b),
        .op  (op),
        .r   (alu_r),
        .ovf (alu_ovf)
    );

    function automatic logic [W-1:0] mag_of(input logic signed [W+1:0] x);
        logic signed [W+1:0] t;
        t = x[W+1] ? -x : x;
        return t[W-1:0];
    endfunction

    // Key decode with num > op > eq priority; out-of-range codes drop the key.
    always_comb begin
        is_num = bus.key_valid && bus.key_is_num && (bus.key_num <= 4'd9);
        is_op  = bus.key_valid && !bus.key_is_num && bus.key_is_op
                 && (bus.key_op <= OP_SUB);
        is_eq  = bus.key_valid && !bus.key_is_num && !bus.key_is_op
                 && bus.key_is_eq;
        d_a    = $signed({{(W-2){1'b0}}, bus.key_num});
        d_b    = {{(W-4){1'b0}}, bus.key_num};
        a_x10  = (a <<< 3) + (a <<< 1) + d_a;
        b_x10  = (b << 3) + (b << 1) + d_b;
    end

    // Next-state and next-operand logic.
    always_comb begin
        nxt  = state;
        a_n  = a;
        b_n  = b;
        r_n  = r;
        op_n = op;
        rv_n = 1'b0;
        unique case (state)
            S_A: begin
                if (is_num) begin
                    if (a < LIM_A) a_n = a_x10;
                end else if (is_op) begin
                    op_n = bus.key_op;
                    nxt  = S_OP;
                end
            end
            S_OP: begin
                if (is_num) begin
                    b_n = d_b;
                    nxt = S_B;
                end else if (is_op) begin
                    op_n = bus.key_op;
                end
            end
            S_B: begin
                if (is_num) begin
                    if (b < LIM_B) b_n = b_x10;
                end else if (is_eq) begin
                    r_n = alu_r;
                    if (alu_ovf) begin
                        nxt = S_ERR;
                    end else begin
                        nxt  = S_RES;
                        rv_n = 1'b1;
                    end
                end
            end
            S_RES: begin
                if (is_num) begin
                    a_n = d_a;
                    b_n = '0;
                    nxt = S_A;
                end
`ifdef CALC_CHAIN_EN
                else if (is_op) begin
                    a_n  = r;
                    op_n = bus.key_op;
                    nxt  = S_OP;
                end
`endif
            end
            S_ERR: begin
                if (is_num) begin
                    a_n = d_a;
                    b_n = '0;
                    nxt = S_A;
                end
            end
            default: nxt = S_A;
        endcase
    end

    // Display values derived from the state being entered.
    always_comb begin
        val_n = '0;
        neg_n = 1'b0;
        err_n = 1'b0;
        unique case (nxt)
            S_A, S_OP: begin
                val_n = mag_of(a_n);
                neg_n = a_n[W+1];
            end
            S_B:   val_n = b_n;
            S_RES: begin
                val_n = mag_of(r_n);
                neg_n = r_n[W+1];
            end
            S_ERR: err_n = 1'b1;
            default: ;
        endcase
    end

    // State, operand and registered output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_A;
            a          <= '0;
            b          <= '0;
            r          <= '0;
            op         <= OP_ADD;
            disp_val_q <= '0;
            disp_neg_q <= 1'b0;
            err_q      <= 1'b0;
            rv_q       <= 1'b0;
        end else begin
            state      <= nxt;
            a          <= a_n;
            b          <= b_n;
            r          <= r_n;
            op         <= op_n;
            disp_val_q <= val_n;
            disp_neg_q <= neg_n;
            err_q      <= err_n;
            rv_q       <= rv_n;
        end
    end

    assign bus.disp_val     = disp_val_q;
    assign bus.disp_neg     = disp_neg_q;
    assign bus.err          = err_q;
    assign bus.result_valid = rv_q;
    assign bus.state_o      = state;
endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: directed key sequences plus random keys,
// checked against an integer calculator model.
module tb_calc_ctrl;
    localparam int W    = 14;
    localparam int NDIG = 4;
    localparam int MAXV = 9999;

    logic clk;
    logic reset;
    bit   started;

    calc_if #(.W(W)) bus ();

    calc_ctrl #(.NDIG(NDIG), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int val;
        bit neg;
        bit err;
        bit rv;
        int st;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    int m_st, m_a, m_b, m_r, m_op;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic push_exp(input bit rv);
        exp_t e;
        e.val = 0;
        e.neg = 0;
        e.err = 0;
        e.rv  = rv;
        e.st  = m_st;
        case (m_st)
            0, 1: begin e.val = iabs(m_a); e.neg = (m_a < 0); end
            2:    e.val = m_b;
            3:    begin e.val = iabs(m_r); e.neg = (m_r < 0); end
            default: e.err = 1;
        endcase
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_op = 0;
        push_exp(0);
    endtask

    task automatic model_key(input bit fn, input bit fo, input bit fe,
                             input int d, input int o);
        bit rv;
        rv = 0;
        if (fn) begin
            if (d <= 9) begin
                case (m_st)
                    0: if (m_a < 1000) m_a = m_a * 10 + d;
                    1: begin m_b = d; m_st = 2; end
                    2: if (m_b < 1000) m_b = m_b * 10 + d;
                    default: begin m_a = d; m_b = 0; m_st = 0; end
                endcase
            end
        end else if (fo) begin
            if (o <= 1) begin
                case (m_st)
                    0: begin m_op = o; m_st = 1; end
                    1: m_op = o;
`ifdef CALC_CHAIN_EN
                    3: begin m_a = m_r; m_op = o; m_st = 1; end
`endif
                    default: ;
                endcase
            end
        end else if (fe) begin
            if (m_st == 2) begin
                m_r = (m_op == 1) ? m_a - m_b : m_a + m_b;
                if (iabs(m_r) > MAXV) m_st = 4;
                else begin m_st = 3; rv = 1; end
            end
        end
        push_exp(rv);
    endtask

    task automatic send(input bit fn, input bit fo, input bit fe,
                        input int d, input int o);
        @(negedge clk);
        bus.key_valid  = 1'b1;
        bus.key_is_num = fn;
        bus.key_is_op  = fo;
        bus.key_is_eq  = fe;
        bus.key_num    = 4'(d);
        bus.key_op     = 2'(o);
        model_key(fn, fo, fe, d, o);
        @(negedge clk);
        bus.key_valid  = 1'b0;
        bus.key_is_num = 1'b0;
        bus.key_is_op  = 1'b0;
        bus.key_is_eq  = 1'b0;
    endtask

    task automatic key_ch(input byte c);
        if (c >= "0" && c <= "9") send(1, 0, 0, int'(c - "0"), 0);
        else if (c == "+")        send(0, 1, 0, 0, 0);
        else if (c == "-")        send(0, 1, 0, 0, 1);
        else                      send(0, 0, 1, 0, 0);
    endtask

    task automatic seq(input string s);
        for (int i = 0; i < s.len(); i++) key_ch(s[i]);
    endtask

    task automatic do_reset(input bit with_key);
        @(negedge clk);
        started        = 1'b1;
        reset          = 1'b1;
        bus.key_valid  = with_key;
        bus.key_is_num = with_key;
        bus.key_num    = 4'd7;
        model_reset();
        @(negedge clk);
        reset          = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_is_num = 1'b0;
    endtask

    // Monitor: every key or reset cycle is checked against the queue head.
    initial begin
        bit   kv, rs;
        exp_t e;
        forever begin
            @(posedge clk);
            kv = bus.key_valid;
            rs = reset;
            #1;
            if (started) begin
                if (kv || rs) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty: got 0 entries expected 1");
                    end else begin
                        e = q.pop_front();
                        chk("disp_val", int'(bus.disp_val), e.val);
                        chk("disp_neg", int'(bus.disp_neg), int'(e.neg));
                        chk("err", int'(bus.err), int'(e.err));
                        chk("result_valid", int'(bus.result_valid), int'(e.rv));
                        chk("state", int'(bus.state_o), e.st);
                    end
                end else begin
                    chk("result_valid_idle", int'(bus.result_valid), 0);
                end
            end
        end
    end

    initial begin
        int k;
        reset          = 1'b1;
        started        = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_is_num = 1'b0;
        bus.key_is_op  = 1'b0;
        bus.key_is_eq  = 1'b0;
        bus.key_num    = 4'd0;
        bus.key_op     = 2'd0;
        repeat (2) @(negedge clk);
        do_reset(0);

        seq("12+34=");
        seq("5-9=");
        seq("7");
        do_reset(0);
        seq("9999+1=");
        seq("=3");
        do_reset(0);
        seq("12345++-5=");
        do_reset(0);
        seq("8+");
        do_reset(1);
        seq("3+4=+2=");
        do_reset(0);
        seq("9999+0=");
        do_reset(0);
        seq("0-9999=");
        do_reset(0);
        seq("9999-9999=");
        do_reset(0);
        send(1, 0, 0, 12, 0);
        send(0, 1, 0, 0, 3);
        send(0, 0, 0, 0, 0);
        send(1, 1, 1, 4, 1);
        send(0, 1, 1, 0, 1);

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 19);
            if (k < 10)       send(1, 0, 0, $urandom_range(0, 9), 0);
            else if (k < 11)  send(1, 0, 0, $urandom_range(0, 15), 0);
            else if (k < 14)  send(0, 1, 0, 0, $urandom_range(0, 1));
            else if (k < 15)  send(0, 1, 0, 0, $urandom_range(0, 3));
            else if (k < 18)  send(0, 0, 1, 0, 0);
            else if (k < 19)  send($urandom_range(0, 1), $urandom_range(0, 1),
                                   $urandom_range(0, 1), $urandom_range(0, 15),
                                   $urandom_range(0, 3));
            else if ($urandom_range(0, 9) == 0) do_reset($urandom_range(0, 1));
            else              send(0, 0, 1, 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
